// File: rtl/prio_enc_scan_pkg.sv
// Shared constants for prio_enc_scan: active-low hex segment codes (bit6=a .. bit0=g)
// and the nibble-to-segment lookup used by hex7seg.
package prio_enc_scan_pkg;

    localparam logic [6:0] SEG_HEX_0 = 7'b0000001;
    localparam logic [6:0] SEG_HEX_1 = 7'b1001111;
    localparam logic [6:0] SEG_HEX_2 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_3 = 7'b0000110;
    localparam logic [6:0] SEG_HEX_4 = 7'b1001100;
    localparam logic [6:0] SEG_HEX_5 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_6 = 7'b0100000;
    localparam logic [6:0] SEG_HEX_7 = 7'b0001111;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0000100;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b1100000;
    localparam logic [6:0] SEG_HEX_C = 7'b0110001;
    localparam logic [6:0] SEG_HEX_D = 7'b1000010;
    localparam logic [6:0] SEG_HEX_E = 7'b0110000;
    localparam logic [6:0] SEG_HEX_F = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_hex(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = SEG_HEX_0;
            4'h1: s = SEG_HEX_1;
            4'h2: s = SEG_HEX_2;
            4'h3: s = SEG_HEX_3;
            4'h4: s = SEG_HEX_4;
            4'h5: s = SEG_HEX_5;
            4'h6: s = SEG_HEX_6;
            4'h7: s = SEG_HEX_7;
            4'h8: s = SEG_HEX_8;
            4'h9: s = SEG_HEX_9;
            4'hA: s = SEG_HEX_A;
            4'hB: s = SEG_HEX_B;
            4'hC: s = SEG_HEX_C;
            4'hD: s = SEG_HEX_D;
            4'hE: s = SEG_HEX_E;
            default: s = SEG_HEX_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/prio_enc_scan_hex7seg.sv
// hex7seg: combinational 4-bit nibble to active-low 7-segment decoder,
// reusable by any display block that imports prio_enc_scan_pkg.
module hex7seg
    import prio_enc_scan_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = seg_hex(nib);

endmodule

// File: rtl/prio_enc_scan.sv
// prio_enc_scan: registered W-bit priority encoder (index + valid flag) shown in hex on
// NDIG scanned 7-segment digits. Optional input debouncer under PRIO_ENC_SCAN_DEBOUNCE_EN.
module prio_enc_scan
    import prio_enc_scan_pkg::*;
#(
    parameter int W         = 16,
    parameter int NDIG      = 2,
    parameter int SCAN_DIV  = 50000,
    parameter int DB_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [W-1:0]          in,
    input  logic                  en,
    input  logic                  hold,
    output logic [$clog2(W)-1:0]  idx,
    output logic                  flag,
    output logic                  changed,
    output logic [6:0]            seg,
    output logic [NDIG-1:0]       an
);

    localparam int IW = $clog2(W);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [NDIG-1:0] AN_RST = ~NDIG'(1);

    if (W < 2 || 4 * NDIG < IW || SCAN_DIV < 1 || DB_CYCLES < 1) begin : g_bad_params
        $error("prio_enc_scan: illegal parameter combination");
    end

    logic [W-1:0] in_q;
    logic [W-1:0] enc_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_q <= '0;
        else        in_q <= in;
    end

`ifdef PRIO_ENC_SCAN_DEBOUNCE_EN
    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [W-1:0]   cand;
    logic [W-1:0]   in_s;
    logic [DBW-1:0] db_cnt;

    // in_s only follows in_q once the same value has been seen DB_CYCLES+1 times in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand   <= '0;
            in_s   <= '0;
            db_cnt <= '0;
        end else if (in_q != cand) begin
            cand   <= in_q;
            db_cnt <= '0;
        end else if (db_cnt == DBW'(DB_CYCLES - 1)) begin
            in_s <= cand;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign enc_src = in_s;
`else
    assign enc_src = in_q;
`endif

    logic [IW-1:0] enc_idx;
    logic [IW-1:0] nxt_idx;
    logic          nxt_flag;

    // Ascending scan: the last set bit seen, i.e. the highest, wins.
    always_comb begin
        enc_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (enc_src[i]) enc_idx = IW'(i);
        end
    end

    always_comb begin
        nxt_idx  = idx;
        nxt_flag = flag;
        if (!hold) begin
            nxt_idx  = en ? enc_idx : '0;
            nxt_flag = en & (|enc_src);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            flag    <= 1'b0;
            changed <= 1'b0;
        end else begin
            idx     <= nxt_idx;
            flag    <= nxt_flag;
            changed <= ({nxt_idx, nxt_flag} != {idx, flag});
        end
    end

    logic [DW-1:0] div_cnt;
    logic [SW-1:0] dig_sel;
    logic          div_wrap;

    assign div_wrap = (div_cnt == DW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            dig_sel <= '0;
        end else if (div_wrap) begin
            div_cnt <= '0;
            dig_sel <= (dig_sel == SW'(NDIG - 1)) ? '0 : dig_sel + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    logic [4*NDIG-1:0] disp;
    logic [3:0]        nib;
    logic [NDIG-1:0]   an_nxt;
    logic [6:0]        seg_nxt;

    // an and seg are both derived from the same dig_sel so they always describe the same digit.
    always_comb begin
        disp = '0;
        if (flag) disp[IW-1:0] = idx;
        nib    = '0;
        an_nxt = '1;
        for (int k = 0; k < NDIG; k++) begin
            if (dig_sel == SW'(k)) begin
                nib       = disp[4*k +: 4];
                an_nxt[k] = 1'b0;
            end
        end
    end

    hex7seg u_hex7seg (
        .nib (nib),
        .seg (seg_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_RST;
            seg <= SEG_HEX_0;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule
